// File: rtl/morse_text_display_pkg.sv
// Shared 7-segment definitions for the Morse decoder and its text display.
package morse_text_display_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Pattern order is ABCDEFG with bit6 = segment A, active-high.
  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_ERR   = 7'b1001001;

  // Output sequencer: a blank GAP cycle separates every pair of SHOW slots.
  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_t;

  // An all-dark pattern carries no letter and is never captured.
  function automatic logic is_letter(input seg_t pattern);
    return pattern != SEG_BLANK;
  endfunction

endpackage

// File: rtl/morse_text_display_if.sv
// Letter input and display output bundle of the Morse text display.
interface morse_text_display_if
  import morse_text_display_pkg::*;
#(
  parameter int DIGITS = 4
) ();

  logic              LetterStb;
  seg_t              LetterD;
  logic              Clr;
  seg_t              SegY;
  logic [DIGITS-1:0] DigY;
  logic [3:0]        CountY;
  logic              FullY;

  modport master (
    output LetterStb, LetterD, Clr,
    input  SegY, DigY, CountY, FullY
  );

  modport slave (
    input  LetterStb, LetterD, Clr,
    output SegY, DigY, CountY, FullY
  );

endinterface

// File: rtl/morse_text_display_ct.sv
// Parameterised wrap-around counter; r flags the enabled terminal count.
module morse_text_display_ct #(
  parameter int W   = 16,
  parameter int INC = 1,
  parameter int MAX = 49_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic r
);

  localparam logic [W-1:0] LAST = W'(MAX);
  localparam logic [W-1:0] STEP = W'(INC);

  logic [W-1:0] q;

  assign r = en && (q == LAST);

  // Advance while enabled, returning to zero after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= r ? '0 : q + STEP;
    end
  end

endmodule

// File: rtl/morse_text_display.sv
// Scrolling letter buffer behind a multiplexed common-anode 7-segment bank.
// Newest letter sits in Buf[0] (rightmost digit); older letters move left.
// The prescaler only runs during SHOW, so every digit is lit for exactly
// SCAN_DIV cycles and the blank anti-ghosting GAP adds one cycle on top.
module morse_text_display
  import morse_text_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                  C,
  input  logic                  aRn,
  morse_text_display_if.slave   bus
);

  localparam int                 IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int                 PS_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0]         COUNT_MAX = 4'(DIGITS);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0]  DIG_ONE   = DIGITS'(1);

  seg_t              text_buf [DIGITS];
  logic [3:0]        count;
  scan_state_t       state;
  logic [IDX_W-1:0]  idx;
  logic              tick;
  logic              take;

  assign take       = bus.LetterStb && is_letter(bus.LetterD);
  assign bus.CountY = count;
  assign bus.FullY  = (count == COUNT_MAX);

  morse_text_display_ct #(
    .W   (PS_W),
    .INC (1),
    .MAX (SCAN_DIV - 1)
  ) u_prescaler (
    .clk   (C),
    .rst_n (aRn),
    .en    (state == ST_SHOW),
    .r     (tick)
  );

  // Text buffer and letter count: clear has priority over a capture.
  always_ff @(posedge C or negedge aRn) begin
    if (!aRn) begin
      for (int i = 0; i < DIGITS; i++) text_buf[i] <= SEG_BLANK;
      count <= '0;
    end else if (bus.Clr) begin
      for (int i = 0; i < DIGITS; i++) text_buf[i] <= SEG_BLANK;
      count <= '0;
    end else if (take) begin
      for (int i = DIGITS - 1; i > 0; i--) text_buf[i] <= text_buf[i-1];
      text_buf[0] <= bus.LetterD;
      if (count != COUNT_MAX) count <= count + 4'd1;
    end
  end

  // Output sequencer with registered segment/digit drive and scan index.
  always_ff @(posedge C or negedge aRn) begin
    if (!aRn) begin
      state   <= ST_GAP;
      idx     <= '0;
      bus.SegY <= SEG_BLANK;
      bus.DigY <= '1;
    end else begin
      case (state)
        ST_GAP: begin
          bus.SegY <= SEG_BLANK;
          bus.DigY <= '1;
          state    <= ST_SHOW;
        end
        ST_SHOW: begin
          bus.SegY <= text_buf[idx];
          bus.DigY <= ~(DIG_ONE << idx);
          if (tick) begin
            state <= ST_GAP;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
        end
        default: begin
          state    <= ST_GAP;
          bus.SegY <= SEG_BLANK;
          bus.DigY <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_text_display.sv
// Bench for morse_text_display: random and directed letters against a
// timeline model (slot = 1 blank cycle + SCAN_DIV lit cycles per digit).
module tb_morse_text_display;
  import morse_text_display_pkg::*;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int SLOT     = SCAN_DIV + 1;
  localparam int ROT      = DIGITS * SLOT;

  logic C   = 1'b0;
  logic aRn = 1'b0;

  morse_text_display_if #(.DIGITS(DIGITS)) bus ();

  morse_text_display #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .C   (C),
    .aRn (aRn),
    .bus (bus)
  );

  always #5 C = ~C;

  int checks   = 0;
  int failures = 0;

  // Reference: letter list newest-first, count, and edges since reset release.
  logic [6:0] mbuf  [DIGITS];
  logic [6:0] mprev [DIGITS];
  int         mcount;
  int         t;

  function automatic bit in_gap();
    return (t == 0) || (((t - 1) % SLOT) == 0);
  endfunction

  function automatic int cur_digit();
    return ((t - 1) / SLOT) % DIGITS;
  endfunction

  function automatic logic [DIGITS-1:0] exp_dig();
    logic [DIGITS-1:0] one;
    one = 1;
    if (in_gap()) return '1;
    return ~(one << cur_digit());
  endfunction

  function automatic logic [6:0] exp_seg();
    if (in_gap()) return 7'h00;
    return mprev[cur_digit()];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DIGITS; i++) begin
      mbuf[i]  = 7'h00;
      mprev[i] = 7'h00;
    end
    mcount = 0;
  endtask

  task automatic step(input logic stb, input logic [6:0] d, input logic clr);
    bus.LetterStb = stb;
    bus.LetterD   = d;
    bus.Clr       = clr;
    mprev = mbuf;
    @(posedge C);
    #1;
    if (clr) begin
      for (int i = 0; i < DIGITS; i++) mbuf[i] = 7'h00;
      mcount = 0;
    end else if (stb && d != 7'h00) begin
      for (int i = DIGITS - 1; i > 0; i--) mbuf[i] = mbuf[i-1];
      mbuf[0] = d;
      if (mcount < DIGITS) mcount++;
    end
    t++;
    bus.LetterStb = 1'b0;
    bus.LetterD   = 7'($urandom);
    bus.Clr       = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge C);
    #3;
    aRn = 1'b0;
    @(negedge C);
    model_clear();
    t   = 0;
    aRn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b1, 7'h3F, 1'b0);
    repeat (3) step(1'b0, 7'h00, 1'b0);
    @(posedge C);
    #3;
    aRn = 1'b0;
    #1;
    checks++;
    if (bus.SegY !== 7'h00) begin
      failures++;
      $display("FAIL reset_seg got=%h exp=00", bus.SegY);
    end
    checks++;
    if (bus.DigY !== 4'b1111) begin
      failures++;
      $display("FAIL reset_dig got=%b exp=1111", bus.DigY);
    end
    checks++;
    if (bus.CountY !== 4'd0 || bus.FullY !== 1'b0) begin
      failures++;
      $display("FAIL reset_count got=%0d/%b exp=0/0", bus.CountY, bus.FullY);
    end
    @(negedge C);
    model_clear();
    t   = 0;
    aRn = 1'b1;
    step(1'b0, 7'h00, 1'b0);
    checks++;
    if (bus.DigY !== 4'b1111) begin
      failures++;
      $display("FAIL reset_edge1_dig got=%b exp=1111", bus.DigY);
    end
    step(1'b0, 7'h00, 1'b0);
    checks++;
    if (bus.DigY !== 4'b1110 || bus.SegY !== 7'h00) begin
      failures++;
      $display("FAIL reset_edge2 got=%b/%h exp=1110/00", bus.DigY, bus.SegY);
    end
  endtask

  task automatic test_capture();
    do_reset();
    step(1'b1, 7'b1110111, 1'b0);
    step(1'b1, 7'b0110000, 1'b0);
    step(1'b1, 7'b1011011, 1'b0);
    checks++;
    if (bus.CountY !== 4'd3 || bus.FullY !== 1'b0) begin
      failures++;
      $display("FAIL capture_count got=%0d/%b exp=3/0", bus.CountY, bus.FullY);
    end
    for (int n = 0; n < ROT + SLOT; n++) begin
      step(1'b0, 7'h00, 1'b0);
      checks++;
      if (bus.DigY !== exp_dig() || bus.SegY !== exp_seg()) begin
        failures++;
        $display("FAIL capture_scan t=%0d got=%b/%h exp=%b/%h", t, bus.DigY, bus.SegY, exp_dig(), exp_seg());
      end
      if (bus.DigY == 4'b1110) begin
        checks++;
        if (bus.SegY !== 7'h5B) begin
          failures++;
          $display("FAIL capture_d0 got=%h exp=5b", bus.SegY);
        end
      end
      if (bus.DigY == 4'b1101) begin
        checks++;
        if (bus.SegY !== 7'h30) begin
          failures++;
          $display("FAIL capture_d1 got=%h exp=30", bus.SegY);
        end
      end
      if (bus.DigY == 4'b1011) begin
        checks++;
        if (bus.SegY !== 7'h77) begin
          failures++;
          $display("FAIL capture_d2 got=%h exp=77", bus.SegY);
        end
      end
    end
  endtask

  task automatic test_scroll();
    logic [6:0] want;
    do_reset();
    for (int k = 1; k <= 6; k++) step(1'b1, 7'(k), 1'b0);
    for (int n = 0; n < ROT + SLOT; n++) begin
      step(1'b0, 7'h00, 1'b0);
      checks++;
      if (bus.CountY !== 4'd4 || bus.FullY !== 1'b1) begin
        failures++;
        $display("FAIL scroll_full got=%0d/%b exp=4/1", bus.CountY, bus.FullY);
      end
      want = 7'h00;
      case (bus.DigY)
        4'b1110: want = 7'h06;
        4'b1101: want = 7'h05;
        4'b1011: want = 7'h04;
        4'b0111: want = 7'h03;
        default: want = 7'h00;
      endcase
      checks++;
      if (bus.SegY !== want) begin
        failures++;
        $display("FAIL scroll_seg dig=%b got=%h exp=%h", bus.DigY, bus.SegY, want);
      end
    end
  endtask

  task automatic test_blank_clear();
    do_reset();
    step(1'b1, 7'h12, 1'b0);
    step(1'b1, 7'h34, 1'b0);
    step(1'b1, 7'h00, 1'b0);
    checks++;
    if (bus.CountY !== 4'd2) begin
      failures++;
      $display("FAIL blank_ignored got=%0d exp=2", bus.CountY);
    end
    for (int n = 0; n < ROT; n++) begin
      step(1'b0, 7'h00, 1'b0);
      checks++;
      if (bus.DigY !== exp_dig() || bus.SegY !== exp_seg()) begin
        failures++;
        $display("FAIL blank_scan t=%0d got=%b/%h exp=%b/%h", t, bus.DigY, bus.SegY, exp_dig(), exp_seg());
      end
    end
    step(1'b1, 7'h56, 1'b1);
    checks++;
    if (bus.CountY !== 4'd0 || bus.FullY !== 1'b0) begin
      failures++;
      $display("FAIL clear_count got=%0d/%b exp=0/0", bus.CountY, bus.FullY);
    end
    step(1'b0, 7'h00, 1'b0);
    for (int n = 0; n < ROT; n++) begin
      step(1'b0, 7'h00, 1'b0);
      checks++;
      if (bus.SegY !== 7'h00 || bus.DigY !== exp_dig()) begin
        failures++;
        $display("FAIL clear_scan t=%0d got=%b/%h exp=%b/00", t, bus.DigY, bus.SegY, exp_dig());
      end
    end
  endtask

  task automatic test_timing();
    logic [DIGITS-1:0] last;
    logic [DIGITS-1:0] cur;
    logic [6:0]        let_d;
    int run;
    int gap;
    int last_idx;
    int idx;
    bit found;
    do_reset();
    last     = '1;
    run      = 0;
    gap      = 0;
    last_idx = DIGITS - 1;
    for (int n = 0; n < 3 * ROT; n++) begin
      step(1'b0, 7'h00, 1'b0);
      cur = bus.DigY;
      if (cur == '1) begin
        if (last != '1) begin
          checks++;
          if (run != SCAN_DIV) begin
            failures++;
            $display("FAIL timing_show_len got=%0d exp=%0d", run, SCAN_DIV);
          end
        end
        gap++;
        run = 0;
      end else if (cur == last) begin
        run++;
      end else begin
        idx = -1;
        for (int b = 0; b < DIGITS; b++) if (cur[b] == 1'b0) idx = b;
        checks++;
        if (last != '1 || gap != 1 || idx != (last_idx + 1) % DIGITS) begin
          failures++;
          $display("FAIL timing_slot dig=%b prev=%b gap=%0d exp_idx=%0d", cur, last, gap, (last_idx + 1) % DIGITS);
        end
        last_idx = idx;
        run = 1;
        gap = 0;
      end
      last = cur;
    end
    for (int n = 0; n < 2 * ROT; n++) begin
      if ((t % SLOT) == SCAN_DIV && ((t / SLOT) % DIGITS) == 0) break;
      step(1'b0, 7'h00, 1'b0);
    end
    let_d = 7'($urandom_range(1, 127));
    step(1'b1, let_d, 1'b0);
    checks++;
    if (bus.DigY !== 4'b1110 || bus.SegY !== 7'h00) begin
      failures++;
      $display("FAIL timing_tick_edge got=%b/%h exp=1110/00", bus.DigY, bus.SegY);
    end
    found = 1'b0;
    for (int n = 0; n < ROT + 2; n++) begin
      step(1'b0, 7'h00, 1'b0);
      if (bus.DigY == 4'b1110) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || bus.SegY !== let_d) begin
      failures++;
      $display("FAIL timing_next_d0 found=%0d got=%h exp=%h", found, bus.SegY, let_d);
    end
  endtask

  task automatic test_error();
    bit found;
    do_reset();
    step(1'b1, 7'h21, 1'b0);
    step(1'b1, SEG_ERR, 1'b0);
    checks++;
    if (bus.CountY !== 4'd2) begin
      failures++;
      $display("FAIL error_count got=%0d exp=2", bus.CountY);
    end
    found = 1'b0;
    for (int n = 0; n < ROT + 2; n++) begin
      step(1'b0, 7'h00, 1'b0);
      if (bus.DigY == 4'b1110) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || bus.SegY !== 7'b1001001) begin
      failures++;
      $display("FAIL error_shown found=%0d got=%h exp=49", found, bus.SegY);
    end
  endtask

  task automatic test_random();
    logic       stb;
    logic       clr;
    logic [6:0] d;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      stb = ($urandom_range(0, 2) == 0);
      d   = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
      clr = ($urandom_range(0, 39) == 0);
      step(stb, d, clr);
      checks++;
      if (bus.DigY !== exp_dig() || bus.SegY !== exp_seg() ||
          bus.CountY !== 4'(mcount) || bus.FullY !== (mcount == DIGITS)) begin
        failures++;
        $display("FAIL random t=%0d got=%b/%h/%0d/%b exp=%b/%h/%0d/%b", t,
                 bus.DigY, bus.SegY, bus.CountY, bus.FullY,
                 exp_dig(), exp_seg(), mcount, (mcount == DIGITS));
      end
    end
  endtask

  initial begin
    bus.LetterStb = 1'b0;
    bus.LetterD   = 7'h00;
    bus.Clr       = 1'b0;
    model_clear();
    t = 0;
    test_reset();
    test_capture();
    test_scroll();
    test_blank_clear();
    test_timing();
    test_error();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
